// File: rtl/thumb_pkg.sv
// thumb_pkg: shared constants and Thumb halfword decode helpers for the fetch aligner
package thumb_pkg;
  localparam logic [15:0] NOP_HW = 16'hBF00;
  localparam int DEF_FETCH_HW = 2;
  localparam int DEF_DEPTH_HW = 8;
  localparam int DEF_PTR_W = $clog2(DEF_DEPTH_HW);
  localparam int DEF_CNT_W = $clog2(DEF_DEPTH_HW + 1);
  function automatic logic is_t32_first(input logic [15:0] hw);
    return hw[15:13] == 3'b111 && hw[12:11] != 2'b00;
  endfunction
  function automatic logic is_multi16(input logic [15:0] hw);
    return hw[15:12] == 4'b1100 || (hw[15:12] == 4'b1011 && hw[10:9] == 2'b10);
  endfunction
endpackage

// File: rtl/hw_ring.sv
// hw_ring: halfword circular buffer, up to FETCH_HW writes and 2-wide head read per cycle
module hw_ring #(
  parameter int FETCH_HW = thumb_pkg::DEF_FETCH_HW,
  parameter int DEPTH_HW = thumb_pkg::DEF_DEPTH_HW,
  localparam int PW = $clog2(DEPTH_HW),
  localparam int CW = $clog2(DEPTH_HW + 1),
  localparam int NW = $clog2(FETCH_HW + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [NW-1:0]            wr_n,
  input  logic [FETCH_HW-1:0][15:0] wr_data,
  input  logic [1:0]               rd_n,
  output logic [15:0]              rd_data0,
  output logic [15:0]              rd_data1,
  output logic [CW-1:0]            count
);
  logic [15:0] mem [DEPTH_HW];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign rd_data0 = mem[rd_ptr];
  assign rd_data1 = mem[rd_ptr + PW'(1)];
  always_ff @(posedge clk) begin
    if (rst_n && !clr)
      for (int i = 0; i < FETCH_HW; i++)
        if (i < int'(wr_n)) mem[wr_ptr + PW'(i)] <= wr_data[i];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_n);
      rd_ptr <= rd_ptr + PW'(rd_n);
      count  <= count + CW'(wr_n) - CW'(rd_n);
    end
  end
endmodule

// File: rtl/thumb_fetch_align.sv
// thumb_fetch_align: splits fetch words into Thumb halfwords and issues 16/32-bit instructions with PC
module thumb_fetch_align #(
  parameter int          FETCH_HW = 2,
  parameter int          DEPTH_HW = 8,
  parameter bit          HI_FIRST = 1'b1,
  parameter logic [15:0] NOP_HW   = thumb_pkg::NOP_HW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [FETCH_HW*16-1:0] fetch_data,
  input  logic                   flush,
  input  logic [31:0]            flush_pc,
  input  logic                   hold,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic                   inst_is32,
  output logic [31:0]            inst_data,
  output logic [31:0]            inst_pc,
  output logic                   inst_multi
);
  import thumb_pkg::*;
  localparam int SW = $clog2(FETCH_HW);
  localparam int CW = $clog2(DEPTH_HW + 1);
  localparam int NW = $clog2(FETCH_HW + 1);
  logic [FETCH_HW-1:0][15:0] ord, wr_data;
  logic [SW-1:0] skip;
  logic [31:0] head_pc;
  logic [15:0] h0, h1;
  logic [CW-1:0] count;
  logic [NW-1:0] wr_n;
  logic [1:0] rd_n;
  logic is32, push, pop;
  always_comb begin
    for (int i = 0; i < FETCH_HW; i++)
      ord[i] = HI_FIRST ? fetch_data[16*(FETCH_HW-1-i) +: 16] : fetch_data[16*i +: 16];
  end
  // halfwords before the redirect target are shifted out so the ring only sees live code
  assign wr_data     = ord >> (16 * int'(skip));
  assign fetch_ready = rst_n && !flush && (CW'(DEPTH_HW) - count) >= CW'(FETCH_HW);
  assign is32        = is_t32_first(h0);
  assign inst_valid  = rst_n && !hold && !flush && count != '0 && (!is32 || count >= CW'(2));
  assign inst_is32   = inst_valid && is32;
  assign inst_multi  = inst_valid && !is32 && is_multi16(h0);
  assign inst_data   = !inst_valid ? {16'h0, NOP_HW} : is32 ? {h0, h1} : {16'h0, h0};
  assign inst_pc     = head_pc;
  assign push        = fetch_valid && fetch_ready;
  assign pop         = inst_valid && inst_ready;
  assign wr_n        = push ? NW'(FETCH_HW) - NW'(skip) : '0;
  assign rd_n        = pop ? (is32 ? 2'd2 : 2'd1) : 2'd0;
  hw_ring #(.FETCH_HW(FETCH_HW), .DEPTH_HW(DEPTH_HW)) u_ring (
    .clk(clk), .rst_n(rst_n), .clr(flush), .wr_n(wr_n), .wr_data(wr_data),
    .rd_n(rd_n), .rd_data0(h0), .rd_data1(h1), .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_pc <= '0;
      skip    <= '0;
    end else if (flush) begin
      head_pc <= {flush_pc[31:1], 1'b0};
      skip    <= flush_pc[SW:1];
    end else begin
      if (pop) head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
      if (push) skip <= '0;
    end
  end
endmodule

// File: tb/tb_thumb_fetch_align.sv
// tb_thumb_fetch_align: directed checks of the Thumb fetch aligner with default parameters
module tb_thumb_fetch_align;
  logic clk = 1'b0;
  logic rst_n, fetch_valid, fetch_ready, flush, hold, inst_valid, inst_ready, inst_is32, inst_multi;
  logic [31:0] fetch_data, flush_pc, inst_data, inst_pc;
  int n_assert = 0;
  int n_fail = 0;
  int acc;
  always #5 clk = ~clk;
  thumb_fetch_align dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .flush(flush), .flush_pc(flush_pc), .hold(hold),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_is32(inst_is32),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_multi(inst_multi)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #2;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_inst(input string tag, input logic v, input logic [31:0] d, input logic [31:0] pc, input logic w32);
    chk({tag, "_valid"}, 32'(inst_valid), 32'(v));
    chk({tag, "_data"}, inst_data, d);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_is32"}, 32'(inst_is32), 32'(w32));
  endtask
  task automatic redirect(input logic [31:0] pc);
    flush = 1'b1;
    flush_pc = pc;
    tick;
    flush = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; fetch_valid = 1'b0; fetch_data = '0; flush = 1'b0; flush_pc = '0;
    hold = 1'b0; inst_ready = 1'b0;
    tick; tick; settle;
    chk("rst_fready", 32'(fetch_ready), 32'd0);
    chk_inst("rst", 1'b0, 32'h0000_BF00, 32'h0, 1'b0);
    chk("rst_multi", 32'(inst_multi), 32'd0);
    rst_n = 1'b1;
    redirect(32'h0);
    settle;
    chk("empty_fready", 32'(fetch_ready), 32'd1);
    chk("empty_valid", 32'(inst_valid), 32'd0);
    // aligned 16-bit stream
    inst_ready = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h2001_2102;
    tick; fetch_valid = 1'b0; settle;
    chk_inst("s16_a", 1'b1, 32'h0000_2001, 32'h0, 1'b0);
    tick; settle;
    chk_inst("s16_b", 1'b1, 32'h0000_2102, 32'h2, 1'b0);
    tick; settle;
    chk_inst("s16_empty", 1'b0, 32'h0000_BF00, 32'h4, 1'b0);
    // 32-bit instruction straddling two fetch words
    redirect(32'h0);
    fetch_valid = 1'b1; fetch_data = 32'h2001_F000;
    tick; fetch_valid = 1'b0; settle;
    chk_inst("sp_a", 1'b1, 32'h0000_2001, 32'h0, 1'b0);
    tick; settle;
    chk_inst("sp_wait1", 1'b0, 32'h0000_BF00, 32'h2, 1'b0);
    tick;
    fetch_valid = 1'b1; fetch_data = 32'hF800_4770; settle;
    chk_inst("sp_wait2", 1'b0, 32'h0000_BF00, 32'h2, 1'b0);
    tick; fetch_valid = 1'b0; settle;
    chk_inst("sp_32", 1'b1, 32'hF000_F800, 32'h2, 1'b1);
    tick; settle;
    chk_inst("sp_c", 1'b1, 32'h0000_4770, 32'h6, 1'b0);
    tick;
    // unaligned redirect skips the first halfword
    redirect(32'h102);
    fetch_valid = 1'b1; fetch_data = 32'hAAAA_BC0F;
    tick; fetch_valid = 1'b0; settle;
    chk_inst("ua", 1'b1, 32'h0000_BC0F, 32'h102, 1'b0);
    chk("ua_multi", 32'(inst_multi), 32'd1);
    tick; settle;
    chk("ua_empty", 32'(inst_valid), 32'd0);
    // backpressure: five words offered into an 8-entry buffer
    redirect(32'h0);
    inst_ready = 1'b0; acc = 0;
    for (int k = 0; k < 5; k++) begin
      fetch_valid = 1'b1;
      fetch_data = {16'(16'h2000 + 2 * k), 16'(16'h2001 + 2 * k)};
      settle;
      if (fetch_ready) acc++;
      tick;
    end
    fetch_valid = 1'b0; settle;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_full_fready", 32'(fetch_ready), 32'd0);
    inst_ready = 1'b1; settle;
    chk_inst("bp_head", 1'b1, 32'h0000_2000, 32'h0, 1'b0);
    tick; settle;
    chk("bp_cnt7_fready", 32'(fetch_ready), 32'd0);
    tick; settle;
    chk("bp_cnt6_fready", 32'(fetch_ready), 32'd1);
    chk_inst("bp_cnt6", 1'b1, 32'h0000_2002, 32'h4, 1'b0);
    // hold stalls issue without losing the head
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle;
      chk("hold_valid", 32'(inst_valid), 32'd0);
      chk("hold_data", inst_data, 32'h0000_BF00);
      tick;
    end
    hold = 1'b0; settle;
    chk_inst("hold_rel", 1'b1, 32'h0000_2002, 32'h4, 1'b0);
    tick; settle;
    chk_inst("pre_rst", 1'b1, 32'h0000_2003, 32'h6, 1'b0);
    // reset mid-stream with five halfwords buffered
    inst_ready = 1'b0; rst_n = 1'b0; settle;
    chk("mrst_fready", 32'(fetch_ready), 32'd0);
    chk("mrst_valid", 32'(inst_valid), 32'd0);
    tick; settle;
    chk_inst("mrst", 1'b0, 32'h0000_BF00, 32'h0, 1'b0);
    rst_n = 1'b1; settle;
    chk("mrst_rel_valid", 32'(inst_valid), 32'd0);
    chk("mrst_rel_fready", 32'(fetch_ready), 32'd1);
    redirect(32'h40);
    fetch_valid = 1'b1; fetch_data = 32'h2222_3333;
    tick; fetch_valid = 1'b0; settle;
    chk_inst("mrst_first", 1'b1, 32'h0000_2222, 32'h40, 1'b0);
    inst_ready = 1'b1;
    tick; settle;
    chk_inst("mrst_second", 1'b1, 32'h0000_3333, 32'h42, 1'b0);
    tick;
    // 32-bit pair wrapping from entry 7 to entry 0
    inst_ready = 1'b0;
    redirect(32'h42);
    fetch_valid = 1'b1; fetch_data = 32'hAAAA_2001; tick;
    fetch_data = 32'h2002_2003; tick;
    fetch_data = 32'h2004_2005; tick;
    fetch_data = 32'h2006_2007; tick;
    fetch_valid = 1'b0; settle;
    chk_inst("wr_head", 1'b1, 32'h0000_2001, 32'h42, 1'b0);
    inst_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick;
    settle;
    chk_inst("wr_drained", 1'b0, 32'h0000_BF00, 32'h50, 1'b0);
    fetch_valid = 1'b1; fetch_data = 32'hF000_F800;
    tick; fetch_valid = 1'b0; settle;
    chk_inst("wr_32", 1'b1, 32'hF000_F800, 32'h50, 1'b1);
    tick; settle;
    chk_inst("wr_after", 1'b0, 32'h0000_BF00, 32'h54, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
